// File: rtl/io_pkg.sv
// Shared definitions for the debounced input port: default widths and the
// debounce FSM state encoding.
package io_pkg;

  localparam int DATA_WIDTH_DEF      = 16;
  localparam int IN_WIDTH_DEF        = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  // A one-cycle debounce still needs a 1-bit counter.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Button synchronizer plus level debouncer; press pulses for one cycle when a
// high level has been stable for DEBOUNCE_CYCLES cycles.
//   state        | meaning
//   RELEASED     | idle, button seen low
//   PRESS_WAIT   | counting stable-high cycles
//   PRESSED      | press accepted, waiting for release
//   RELEASE_WAIT | counting stable-low cycles
module debouncer
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic press
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  deb_state_e       r_state;
  deb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= RELEASED;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter never reaches past CNT_LAST: the state exits on that value.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    case (r_state)
      RELEASED: begin
        if (r_sync2) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = RELEASED;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_press     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!r_sync2) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (r_sync2) begin
          w_state_nxt = PRESSED;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = RELEASED;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign press = w_press;

endmodule

// File: rtl/input_port.sv
// CPU input port: debounced button captures the synchronized switch value into
// a one-deep holding register with valid and sticky overrun flags.
module input_port
  import io_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int IN_WIDTH        = IN_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn,
  input  logic [IN_WIDTH-1:0]   sw,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  overrun
);

  logic [IN_WIDTH-1:0]   r_sw_sync1;
  logic [IN_WIDTH-1:0]   r_sw_sync2;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  w_press;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .rst  (rst),
    .in   (btn),
    .press(w_press)
  );

  // A read in the same cycle as a press frees the slot, so that press is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_sw_sync1 <= sw;
      r_sw_sync2 <= r_sw_sync1;
      if (w_press && (!r_valid || rd)) begin
        r_data  <= DATA_WIDTH'(r_sw_sync2);
        r_valid <= 1'b1;
      end else if (w_press) begin
        r_overrun <= 1'b1;
      end else if (rd && r_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data    = r_data;
  assign valid   = r_valid;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_input_port.sv
// Directed bench for input_port: expected captures go into a scoreboard queue
// and a monitor matches them against each rising edge of valid.
module tb_input_port;

  localparam int DW = 16;
  localparam int IW = 4;
  localparam int DB = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn;
  logic [IW-1:0] sw;
  logic          rd;
  logic [DW-1:0] data;
  logic          valid;
  logic          overrun;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_valid = 1'b0;
  exp_t q[$];
  exp_t mon_e;

  input_port #(
    .DATA_WIDTH     (DW),
    .IN_WIDTH       (IW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .sw     (sw),
    .rd     (rd),
    .data   (data),
    .valid  (valid),
    .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  // Capture is expected DB+3 edges after btn is first sampled high.
  task automatic push_capture(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + DB + 3;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1 && prev_valid === 1'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_capture", {16'h0, data}, 32'hDEAD_BEEF);
      end else begin
        mon_e = q.pop_front();
        chk("cap_data", {16'h0, data}, {16'h0, mon_e.data});
        chk("cap_cycle", cyc, mon_e.cyc);
      end
    end
    prev_valid = valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; btn = 1'b0; rd = 1'b0; sw = '0;
    step(2);
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    step(2);

    // read while empty is ignored
    rd = 1'b1; step(1); rd = 1'b0;
    @(negedge clk);
    chk("idle_rd_valid", valid, 0);
    chk("idle_rd_data", data, 0);
    chk("idle_rd_ovr", overrun, 0);

    // long hold gives exactly one capture at edge 7
    sw = 4'hA; step(3);
    btn = 1'b1; push_capture(16'h000A);
    step(20);
    btn = 1'b0; step(10);
    @(negedge clk);
    chk("hold_valid", valid, 1);
    chk("hold_data", data, 16'h000A);
    rd = 1'b1; step(1); rd = 1'b0;
    @(negedge clk);
    chk("rd_clear_valid", valid, 0);
    chk("rd_keep_data", data, 16'h000A);

    // glitches shorter than the debounce window
    btn = 1'b1; step(3);
    btn = 1'b0; step(2);
    btn = 1'b1; step(2);
    btn = 1'b0; step(10);
    @(negedge clk);
    chk("glitch_valid", valid, 0);
    chk("glitch_data", data, 16'h000A);

    // second press without a read sets overrun
    sw = 4'h3; step(3);
    btn = 1'b1; push_capture(16'h0003);
    step(10);
    btn = 1'b0; step(10);
    @(negedge clk);
    chk("ovr_before", overrun, 0);
    sw = 4'h5; step(3);
    btn = 1'b1; step(10);
    btn = 1'b0; step(10);
    @(negedge clk);
    chk("ovr_data", data, 16'h0003);
    chk("ovr_valid", valid, 1);
    chk("ovr_flag", overrun, 1);
    rd = 1'b1; step(1); rd = 1'b0;
    @(negedge clk);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_rd_valid", valid, 0);

    // press completing in the same cycle as rd
    rst = 1'b1; step(1); rst = 1'b0;
    @(negedge clk);
    chk("rst_clears_ovr", overrun, 0);
    sw = 4'h3; step(3);
    btn = 1'b1; push_capture(16'h0003);
    step(10);
    btn = 1'b0; step(10);
    sw = 4'h5; step(3);
    btn = 1'b1; step(DB + 2);
    rd = 1'b1; step(1); rd = 1'b0;
    @(negedge clk);
    chk("coinc_data", data, 16'h0005);
    chk("coinc_valid", valid, 1);
    chk("coinc_ovr", overrun, 0);
    btn = 1'b0; step(10);
    @(negedge clk);
    chk("coinc_valid_hold", valid, 1);

    // reset at debounce count 2 with the button held
    sw = 4'h9; step(3);
    btn = 1'b1; step(5);
    rst = 1'b1; step(1); rst = 1'b0;
    push_capture(16'h0009);
    @(negedge clk);
    chk("abort_valid", valid, 0);
    chk("abort_data", data, 0);
    step(20);
    btn = 1'b0; step(10);
    @(negedge clk);
    chk("abort_final_data", data, 16'h0009);

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_port.md
INPUT_PORT -- requirements
Module: input_port

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the width of the data word presented to the cpu.
REQ-002 The block SHALL have parameter IN_WIDTH, default 4, the number of switch bits captured.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, the number of consecutive stable cycles required to accept a button level change.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port btn, input, 1 bit, the raw asynchronous push button, high when pressed.
REQ-007 The block SHALL have port sw, input, IN_WIDTH bits, the raw switch value sampled on a press.
REQ-008 The block SHALL have port rd, input, 1 bit, a cpu read strobe that is one cycle wide.
REQ-009 The block SHALL have port data, output, DATA_WIDTH bits, the captured switch value, zero-extended.
REQ-010 The block SHALL have port valid, output, 1 bit, high while data is unread.
REQ-011 The block SHALL have port overrun, output, 1 bit, a sticky flag indicating that a press was lost.

Function
REQ-012 btn SHALL pass through a two-flop synchronizer before any other use.
REQ-013 The debounce FSM SHALL have the states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-014 In RELEASED, a synchronized high SHALL move the FSM to PRESS_WAIT and clear the counter.
REQ-015 In PRESS_WAIT, the counter SHALL increment on each cycle the synchronized level is high, and a low SHALL return the FSM to RELEASED.
REQ-016 In PRESS_WAIT, reaching DEBOUNCE_CYCLES-1 while the level is high SHALL move the FSM to PRESSED and generate a one-cycle press pulse.
REQ-017 The PRESSED to RELEASE_WAIT to RELEASED path SHALL mirror REQ-014 to REQ-016 with the level low, and SHALL generate no pulse.
REQ-018 The counter SHALL be $clog2(DEBOUNCE_CYCLES) bits wide, saturate only by state exit, and never wrap.
REQ-019 On a press pulse with valid=0, sw SHALL be synchronized and registered into data[IN_WIDTH-1:0], the upper bits SHALL be 0, and valid SHALL be set on the next edge.
REQ-020 The total latency from btn first sampled high to valid high SHALL be DEBOUNCE_CYCLES+3 clk edges, given a stable btn.
REQ-021 rd with valid=1 SHALL clear valid on the next edge, and data SHALL hold its value.
REQ-022 rd with valid=0 SHALL be ignored.
REQ-023 A press pulse with valid=1 and rd=0 SHALL set overrun and leave data and valid unchanged.
REQ-024 A press pulse and rd in the same cycle SHALL capture the new data, keep valid=1, and leave overrun unchanged.
REQ-025 overrun SHALL stay set until rst is asserted.
REQ-026 A press held for any duration SHALL produce exactly one capture.

Reset
REQ-027 rst SHALL force the synchronizer flops to 0, the FSM to RELEASED, the counter to 0, data to 0, valid to 0 and overrun to 0 on the next edge.
REQ-028 rst asserted mid-debounce or while the button is held SHALL abort the operation with no capture, and a held button SHALL require the full DEBOUNCE_CYCLES after rst is released to register.

Structure
REQ-029 The FSM state encoding and the default widths SHALL be defined in a shared package, io_pkg.
REQ-030 The synchronizer, FSM and counter SHALL be implemented as one sub-module, debouncer, with ports clk, rst, in and press, instantiated once inside input_port.
REQ-031 input_port SHALL be instantiated in the top level in place of the direct switch wiring to the cpu in port, with rd driven by the cpu IN instruction decode.

Verification
All scenarios SHALL run with DEBOUNCE_CYCLES=4 and IN_WIDTH=4.
REQ-032 Stimulus: sw=4'hA, btn held high for 20 cycles -> valid rises at edge 7, data=16'h000A, and valid rises exactly once.
REQ-033 Stimulus: btn glitching high for 3 cycles, low, then high for 2 cycles -> valid stays 0.
REQ-034 Stimulus: a press with sw=3, then a press with sw=5 and no rd -> data=16'h0003, valid=1, overrun=1.
REQ-035 Stimulus: valid=1 with data=3, then a press with sw=5 completing in the same cycle as rd -> data=16'h0005, valid=1, overrun=0.
REQ-036 Stimulus: rst pulsed at debounce count 2 with btn held -> no capture; valid rises 7 edges after rst deasserts.
REQ-037 Stimulus: rd with valid=0 -> valid, data and overrun unchanged; a subsequent rd after a capture -> valid=0 next cycle and data unchanged.
